// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants: register file geometry defaults and
// ABI register indices used when naming architectural registers.
package riscv_pkg;

    localparam int WORDSIZE_DEFAULT   = 64;
    localparam int REG_COUNT_DEFAULT  = 32;
    localparam int ADDR_WIDTH_DEFAULT = 5;

    // x0 is architecturally hardwired to zero
    localparam int ZERO_REG = 0;

    // ABI names for the low registers
    localparam int RA = 1;
    localparam int SP = 2;

endpackage

// File: rtl/n_bits_register.sv
// Single n-bit storage word with synchronous active-high clear and a load
// strobe. Clear wins over load, so a write in a reset cycle is dropped.
module n_bits_register #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         load,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    // Next value: take new data only when loaded, otherwise hold
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = data_in;
        end
    end

    // Word register with synchronous clear taking priority over load
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/register_file.sv
// Addressed register file: REG_COUNT words of WORDSIZE bits, two
// combinational read ports, one clocked write port and optional
// write-first forwarding. x0 and any index past REG_COUNT have no storage
// and read as zero; writes to them are dropped.
module register_file
    import riscv_pkg::*;
#(
    parameter int WORDSIZE   = WORDSIZE_DEFAULT,
    parameter int REG_COUNT  = REG_COUNT_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORDSIZE-1:0]   write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [WORDSIZE-1:0]   read_data_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [WORDSIZE-1:0]   read_data_2
);

    // Every encodable address gets a slot so the read mux never indexes
    // out of range; slots without storage are tied to zero.
    localparam int SLOTS = 2 ** ADDR_WIDTH;

    logic [WORDSIZE-1:0] slot_data [SLOTS];
    logic [SLOTS-1:0]    writable;
    logic                bypass_1;
    logic                bypass_2;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i != ZERO_REG && i < REG_COUNT) begin : g_word
            assign writable[i] = 1'b1;
            n_bits_register #(
                .N(WORDSIZE)
            ) u_word (
                .clk      (clk),
                .load     (write_enable && (write_addr == ADDR_WIDTH'(i))),
                .reset    (reset),
                .data_in  (write_data),
                .data_out (slot_data[i])
            );
        end else begin : g_zero
            assign writable[i]  = 1'b0;
            assign slot_data[i] = '0;
        end
    end

    // Read muxes with write-first forwarding; reset suppresses forwarding
    // and only real storage slots can forward
    always_comb begin
        bypass_1 = (BYPASS != 0) && write_enable && !reset
                   && (write_addr == read_addr_1) && writable[write_addr];
        bypass_2 = (BYPASS != 0) && write_enable && !reset
                   && (write_addr == read_addr_2) && writable[write_addr];
        read_data_1 = bypass_1 ? write_data : slot_data[read_addr_1];
        read_data_2 = bypass_2 ? write_data : slot_data[read_addr_2];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. Two instances share one set of
// inputs: dut (defaults, forwarding on) and dutNb (24 registers, no
// forwarding) so out-of-range indices and the non-forwarding path are
// both exercised. A plain array model tracks expected contents.
module tb_register_file;
    import riscv_pkg::*;

    localparam int NB_COUNT = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [63:0] writeData;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] nbRd1;
    logic [63:0] nbRd2;

    int passCount  = 0;
    int checkCount = 0;

    // Reference contents of each instance
    logic [63:0] refMem   [32];
    logic [63:0] refMemNb [32];

    register_file dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (writeEnable),
        .write_addr   (writeAddr),
        .write_data   (writeData),
        .read_addr_1  (readAddr1),
        .read_data_1  (rd1),
        .read_addr_2  (readAddr2),
        .read_data_2  (rd2)
    );

    register_file #(
        .REG_COUNT (NB_COUNT),
        .BYPASS    (0)
    ) dutNb (
        .clk          (clk),
        .reset        (reset),
        .write_enable (writeEnable),
        .write_addr   (writeAddr),
        .write_data   (writeData),
        .read_addr_1  (readAddr1),
        .read_data_1  (nbRd1),
        .read_addr_2  (readAddr2),
        .read_data_2  (nbRd2)
    );

    always #5 clk = ~clk;

    // Expected read of the forwarding instance under the current inputs
    function automatic logic [63:0] expFwd(input logic [4:0] a);
        if (!reset && writeEnable && writeAddr == a && a != 0) return writeData;
        if (a == 0) return 64'h0;
        return refMem[a];
    endfunction

    // Expected read of the 24-register non-forwarding instance
    function automatic logic [63:0] expNb(input logic [4:0] a);
        if (a == 0 || int'(a) >= NB_COUNT) return 64'h0;
        return refMemNb[a];
    endfunction

    // Advance one clock edge, apply the same edge to the model, then step
    // clear of the edge so inputs can change and outputs can settle
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                refMem[i]   = 64'h0;
                refMemNb[i] = 64'h0;
            end
        end else if (writeEnable && writeAddr != 0) begin
            refMem[writeAddr] = writeData;
            if (int'(writeAddr) < NB_COUNT) refMemNb[writeAddr] = writeData;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; writeEnable = 1'b0; writeAddr = 5'd0; writeData = '0;
        readAddr1 = 5'd5; readAddr2 = 5'd31;
        tick();
        reset = 1'b0;
        #1;
        checkCount++;
        if (rd1 !== 64'h0) $display("[TB] FAIL reset_rd1: got %h expected %h", rd1, 64'h0);
        else passCount++;
        checkCount++;
        if (rd2 !== 64'h0) $display("[TB] FAIL reset_rd2: got %h expected %h", rd2, 64'h0);
        else passCount++;
        checkCount++;
        if (nbRd1 !== 64'h0) $display("[TB] FAIL reset_nb_rd1: got %h expected %h", nbRd1, 64'h0);
        else passCount++;
    endtask

    task automatic test_write_read();
        writeEnable = 1'b1; writeAddr = 5'd7; writeData = 64'h14a7_e226_fc32_92a1;
        tick();
        writeEnable = 1'b0; readAddr1 = 5'd7; readAddr2 = 5'd6;
        #1;
        checkCount++;
        if (rd1 !== 64'h14a7_e226_fc32_92a1)
            $display("[TB] FAIL write_read_x7: got %h expected %h", rd1, 64'h14a7_e226_fc32_92a1);
        else passCount++;
        checkCount++;
        if (rd2 !== 64'h0) $display("[TB] FAIL write_read_x6: got %h expected %h", rd2, 64'h0);
        else passCount++;
        checkCount++;
        if (nbRd1 !== 64'h14a7_e226_fc32_92a1)
            $display("[TB] FAIL write_read_nb_x7: got %h expected %h", nbRd1, 64'h14a7_e226_fc32_92a1);
        else passCount++;
    endtask

    task automatic test_x0();
        writeEnable = 1'b1; writeAddr = 5'd0; writeData = '1;
        readAddr1 = 5'd0; readAddr2 = 5'd0;
        #1;
        checkCount++;
        if (rd1 !== 64'h0) $display("[TB] FAIL x0_write_cycle: got %h expected %h", rd1, 64'h0);
        else passCount++;
        tick();
        writeEnable = 1'b0;
        #1;
        checkCount++;
        if (rd2 !== 64'h0) $display("[TB] FAIL x0_after_edge: got %h expected %h", rd2, 64'h0);
        else passCount++;
        checkCount++;
        if (nbRd1 !== 64'h0) $display("[TB] FAIL x0_nb_after_edge: got %h expected %h", nbRd1, 64'h0);
        else passCount++;
    endtask

    task automatic test_bypass();
        writeEnable = 1'b1; writeAddr = 5'd3; writeData = 64'h1111;
        tick();
        writeData = 64'h2222; readAddr1 = 5'd3; readAddr2 = 5'd3;
        #1;
        checkCount++;
        if (rd1 !== 64'h2222) $display("[TB] FAIL bypass_rd1: got %h expected %h", rd1, 64'h2222);
        else passCount++;
        checkCount++;
        if (rd2 !== 64'h2222) $display("[TB] FAIL bypass_rd2: got %h expected %h", rd2, 64'h2222);
        else passCount++;
        checkCount++;
        if (nbRd1 !== 64'h1111) $display("[TB] FAIL nobypass_before: got %h expected %h", nbRd1, 64'h1111);
        else passCount++;
        checkCount++;
        if (nbRd2 !== 64'h1111) $display("[TB] FAIL nobypass_before_rd2: got %h expected %h", nbRd2, 64'h1111);
        else passCount++;
        tick();
        writeEnable = 1'b0;
        #1;
        checkCount++;
        if (nbRd1 !== 64'h2222) $display("[TB] FAIL nobypass_after: got %h expected %h", nbRd1, 64'h2222);
        else passCount++;
    endtask

    task automatic test_hold();
        writeEnable = 1'b1; writeAddr = 5'd9; writeData = '1;
        tick();
        writeEnable = 1'b0; writeData = '0; readAddr1 = 5'd9; readAddr2 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkCount++;
            if (rd1 !== 64'hffff_ffff_ffff_ffff)
                $display("[TB] FAIL hold_x9_cycle%0d: got %h expected %h", c, rd1, 64'hffff_ffff_ffff_ffff);
            else passCount++;
        end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; writeEnable = 1'b1; writeAddr = 5'd9; writeData = 64'habcd;
        readAddr1 = 5'd9; readAddr2 = 5'd9;
        #1;
        checkCount++;
        if (rd1 !== 64'hffff_ffff_ffff_ffff)
            $display("[TB] FAIL rstprio_during: got %h expected %h", rd1, 64'hffff_ffff_ffff_ffff);
        else passCount++;
        checkCount++;
        if (nbRd2 !== 64'hffff_ffff_ffff_ffff)
            $display("[TB] FAIL rstprio_during_nb: got %h expected %h", nbRd2, 64'hffff_ffff_ffff_ffff);
        else passCount++;
        tick();
        reset = 1'b0; writeEnable = 1'b0;
        for (int a = 0; a < 32; a += 3) begin
            readAddr1 = 5'(a); readAddr2 = 5'(31 - a);
            #1;
            checkCount++;
            if (rd1 !== 64'h0 || rd2 !== 64'h0)
                $display("[TB] FAIL rstprio_after_x%0d: got %h/%h expected 0", a, rd1, rd2);
            else passCount++;
        end
        readAddr1 = 5'd9;
        #1;
        checkCount++;
        if (rd1 !== 64'h0) $display("[TB] FAIL rstprio_x9: got %h expected %h", rd1, 64'h0);
        else passCount++;
    endtask

    task automatic test_out_of_range();
        writeEnable = 1'b1; writeAddr = 5'd25; writeData = 64'hdead_beef_0000_0025;
        readAddr1 = 5'd25; readAddr2 = 5'd25;
        #1;
        checkCount++;
        if (nbRd1 !== 64'h0) $display("[TB] FAIL oor_write_cycle: got %h expected %h", nbRd1, 64'h0);
        else passCount++;
        tick();
        writeEnable = 1'b0;
        #1;
        checkCount++;
        if (nbRd1 !== 64'h0) $display("[TB] FAIL oor_after_edge: got %h expected %h", nbRd1, 64'h0);
        else passCount++;
        checkCount++;
        if (rd1 !== 64'hdead_beef_0000_0025)
            $display("[TB] FAIL inrange_x25: got %h expected %h", rd1, 64'hdead_beef_0000_0025);
        else passCount++;
    endtask

    task automatic test_abi();
        writeEnable = 1'b1; writeAddr = 5'(RA); writeData = 64'h0000_0000_8000_0004;
        tick();
        writeAddr = 5'(SP); writeData = 64'h0000_0000_7fff_fff0;
        tick();
        writeEnable = 1'b0; readAddr1 = 5'(RA); readAddr2 = 5'(SP);
        #1;
        checkCount++;
        if (rd1 !== 64'h0000_0000_8000_0004 || rd2 !== 64'h0000_0000_7fff_fff0)
            $display("[TB] FAIL abi_ra_sp: got %h/%h expected %h/%h", rd1, rd2,
                     64'h0000_0000_8000_0004, 64'h0000_0000_7fff_fff0);
        else passCount++;
    endtask

    task automatic test_random();
        logic [63:0] e1, e2, n1, n2;
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 31) == 0);
            writeEnable = ($urandom_range(0, 3) != 0);
            writeAddr   = 5'($urandom_range(0, 31));
            writeData   = {$urandom, $urandom};
            readAddr1   = ($urandom_range(0, 2) == 0) ? writeAddr : 5'($urandom_range(0, 31));
            readAddr2   = ($urandom_range(0, 2) == 0) ? writeAddr : 5'($urandom_range(0, 31));
            #1;
            e1 = expFwd(readAddr1); e2 = expFwd(readAddr2);
            n1 = expNb(readAddr1);  n2 = expNb(readAddr2);
            checkCount++;
            if (rd1 !== e1 || rd2 !== e2 || nbRd1 !== n1 || nbRd2 !== n2)
                $display("[TB] FAIL random_c%0d: got %h %h %h %h expected %h %h %h %h",
                         c, rd1, rd2, nbRd1, nbRd2, e1, e2, n1, n2);
            else passCount++;
            tick();
        end
        reset = 1'b0; writeEnable = 1'b0;
    endtask

    // Run each scenario in order, then report
    initial begin
        for (int i = 0; i < 32; i++) begin
            refMem[i]   = 64'h0;
            refMemNb[i] = 64'h0;
        end
        reset = 1'b1; writeEnable = 1'b0; writeAddr = '0; writeData = '0;
        readAddr1 = '0; readAddr2 = '0;
        #1;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_hold();
        test_reset_priority();
        test_out_of_range();
        test_abi();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Parametrised multi-register storage block for the RISC-V datapath: REG_COUNT general-purpose registers of WORDSIZE bits each.
- Two combinational read ports and one clocked write port.
- Register x0 is hardwired to zero.
- Optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port). It generalises the single n-bit register cell to an addressed array.

Parameters:
WORDSIZE, 64, width of each register and of all data ports
REG_COUNT, 32, number of architectural registers, including x0
ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= REG_COUNT
BYPASS, 1, 1 = write-first forwarding to read ports in the write cycle; 0 = read returns stored value only

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all registers on rising edge
write_enable  input  1  commit write_data to write_addr on rising edge
write_addr  input  ADDR_WIDTH  destination register index
write_data  input  WORDSIZE  data to be written
read_addr_1  input  ADDR_WIDTH  source register index, port 1
read_data_1  output  WORDSIZE  contents of read_addr_1, combinational
read_addr_2  input  ADDR_WIDTH  source register index, port 2
read_data_2  output  WORDSIZE  contents of read_addr_2, combinational

Behaviour:
- Storage:
  - Registers 1..REG_COUNT-1 are flip-flop words.
  - Register 0 has no storage and always reads 0.
- Reset:
  - Sampled only at the rising clk edge; no asynchronous effect.
  - Reset = 1 at an edge sets every register to 0.
  - Reset has priority over write_enable; a write in the same cycle is discarded.
- Write:
  - At a rising edge with reset = 0 and write_enable = 1, register[write_addr] takes write_data. Latency is 1 cycle.
  - Writes to index 0 are ignored.
  - Writes to an index >= REG_COUNT are ignored.
  - write_enable = 0 leaves all contents unchanged whatever write_data is.
- Read:
  - Purely combinational; read_data_n follows read_addr_n in the same cycle.
  - Index 0 reads 0.
  - An index >= REG_COUNT reads 0.
- Bypass (BYPASS = 1):
  - Forwarding applies when write_enable = 1, reset = 0, write_addr == read_addr_n, write_addr != 0 and write_addr < REG_COUNT.
  - Under those conditions read_data_n = write_data in the same cycle, before the edge.
  - Both ports may bypass simultaneously.
  - Bypass is suppressed while reset = 1.
- No bypass (BYPASS = 0): read_data_n shows the old value until the edge and the new value from the following cycle.
- Both read ports at the same address return identical data.
- Outputs after reset: every non-bypassed read returns 0 until written.
- Reset asserted mid-stream:
  - During the reset cycle, reads still show the pre-reset contents (BYPASS never forwards).
  - From the next cycle, reads return 0.
- No X propagation: reads of never-written registers after reset return 0.

Decomposition:
- Shared package riscv_pkg holds:
  - WORDSIZE_DEFAULT = 64, REG_COUNT_DEFAULT = 32, ADDR_WIDTH_DEFAULT = 5
  - ZERO_REG = 0
  - ABI register index constants (e.g. RA = 1, SP = 2)
- Storage word: one instance of the existing n_bits_register cell (clk, load, reset, data_in, data_out) per register 1..REG_COUNT-1, generated in a loop.
  - load is the decoded write strobe: write_enable & (write_addr == i).
  - reset is wired straight through.
- Read muxes and bypass compare stay in register_file; no further sub-module.

Test Plan:
1. Reset then read: reset = 1 for one edge, then read_addr_1 = 5, read_addr_2 = 31 → both read 0x0000_0000_0000_0000.
2. Write/read: write x7 = 0x14a7_e226_fc32_92a1 at edge; next cycle read_addr_1 = 7 → 0x14a7_e226_fc32_92a1. read_addr_2 = 6 → 0.
3. x0 immunity: write_enable = 1, write_addr = 0, write_data = 0xffff_ffff_ffff_ffff → read x0 returns 0 in the write cycle and after the edge.
4. Bypass: BYPASS = 1, x3 holds 0x1111, write x3 = 0x2222, read_addr_1 = read_addr_2 = 3 → both read 0x2222 before the edge. Repeat with BYPASS = 0 → 0x1111 before the edge, 0x2222 after.
5. Hold and load gating: write x9 = 0xffff_ffff_ffff_ffff, then write_enable = 0 with write_data = 0 for 3 cycles → x9 stays 0xffff_ffff_ffff_ffff.
6. Reset priority: x9 = 0xffff_ffff_ffff_ffff, then reset = 1 and write_enable = 1 to x9 with 0xabcd in the same cycle. During that cycle x9 reads 0xffff_ffff_ffff_ffff with no bypass; after the edge x9 and all others read 0.
